df_tile_iterator: RTL and testbench
===================================

# df_tile_iterator

Parametrised tile-loop sequencer for the dataflow controller. From a latched tile-loop configuration (x/y/k/c limits plus per-operand steps), it walks the four-level tile nest and emits one tile descriptor per valid/ready beat. Each descriptor carries the psums, ifmaps and weights offsets plus reduction-boundary flags. Two selectable loop orders and generic widths replace the fixed 12/24-bit tile pointer layout. It sits between the controller configuration registers and the DMA/feeder address logic.

## Interface
- ADDR_W, 24, width of every step input and offset output
- CNT_W, 12, width of tile limits and internal loop counters
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_clear  in  1  synchronous abort; returns to IDLE
- i_order  in  1  loop order: 0 = c,x,y,k (inner→outer); 1 = x,y,c,k
- i_x_lim, i_y_lim, i_k_lim, i_c_lim  in  CNT_W each  last tile index (tile count − 1)
- i_ps_x_step, i_ps_y_step, i_ps_k_step  in  ADDR_W each  psums steps
- i_if_x_step, i_if_y_step, i_if_c_step  in  ADDR_W each  ifmaps steps
- i_wt_k_step, i_wt_c_step  in  ADDR_W each  weights steps
- o_valid  out  1  descriptor valid
- i_ready  in  1  consumer accepts descriptor
- o_ps_offs, o_if_offs, o_wt_offs  out  ADDR_W each  tile offsets
- o_first_c  out  1  current tile has c == 0 (psums preload/clear)
- o_last_c  out  1  current tile has c == c_lim (psums writeback)
- o_last  out  1  final tile of the nest
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse after the final accept

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: on i_start, latch all limits, steps and i_order, zero the counters, go to RUN. Inputs other than i_ready/i_clear are ignored until the next IDLE.
- RUN: o_valid = 1. Descriptor for the counters (x,y,k,c):
  - ps = x·ps_x + y·ps_y + k·ps_k
  - if = x·if_x + y·if_y + c·if_c
  - wt = k·wt_k + c·wt_c
  - All sums are mod 2^ADDR_W; overflow wraps silently.
  - Implemented with incrementally updated per-dimension contribution registers (add step on increment, clear on wrap). No multipliers.
- Accept (o_valid & i_ready): the innermost counter increments. At its limit it wraps to 0 and carries to the next level, per i_order. Accept when o_last = 1 → DONE.
- o_last = all four counters at their limits.
- DONE: o_done = 1, o_valid = 0 for one cycle, then IDLE.
- i_clear in any state: next cycle IDLE, o_valid = 0, no o_done. i_clear has priority over i_start and over an accept in the same cycle.
- i_start during RUN/DONE: ignored.

## Timing
- Reset: state IDLE; all outputs 0; counters and contributions 0.
- Descriptor outputs are registered.
- First descriptor valid in the cycle after i_start is sampled.
- Throughput: one descriptor per cycle under continuous i_ready.
- With i_ready low, o_valid and all descriptor fields hold stable.
- o_done is asserted the cycle after the final accept; o_busy drops one cycle later.
- Total accepts = (x_lim+1)(y_lim+1)(k_lim+1)(c_lim+1).

## Test plan
- Order 0: limits x=1, y=0, k=0, c=1; ps_x=4, if_x=4, if_c=100, wt_c=8, other steps 0; i_ready = 1.
  - Required: ps 0,0,4,4; if 0,100,4,104; wt 0,8,0,8; first_c 1,0,1,0; last_c 0,1,0,1; last only on beat 4; o_done on the next cycle.
- Same configuration with order 1:
  - Required: ps 0,4,0,4; if 0,4,100,104; wt 0,0,8,8; first_c 1,1,0,0; last_c 0,0,1,1.
- All limits 0:
  - Required: exactly one beat with offsets 0 and first_c = last_c = last = 1, then o_done.
- Wrap: ADDR_W = 24, x_lim = 2, ps_x = 0xFFFFFF.
  - Required: ps 0x000000, 0xFFFFFF, 0xFFFFFE.
- Backpressure: run the first scenario with i_ready toggling 1,0,0,1,…
  - Required: fields stable while stalled; sequence identical to the first scenario.
- i_clear asserted on beat 2 of the first scenario, with i_start asserted in the same cycle:
  - Required: IDLE next cycle, no o_done.
  - A fresh i_start afterwards restarts from offsets 0.
- Async reset asserted mid-RUN:
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/df_tile_iterator.sv
// df_tile_iterator
// Walks a four-level (x, y, k, c) tile nest and emits one tile descriptor
// per valid/ready beat. Each descriptor carries the psums, ifmaps and
// weights offsets and the c-reduction boundary flags.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_start, i_clear       start pulse (IDLE only), synchronous abort
//   i_order                0: c,x,y,k (inner->outer); 1: x,y,c,k
//   i_*_lim                last tile index per dimension
//   i_ps_*/i_if_*/i_wt_*   per-operand address steps
//   o_valid, i_ready       descriptor handshake
//   o_ps_offs/o_if_offs/o_wt_offs  registered tile offsets
//   o_first_c, o_last_c, o_last    boundary flags
//   o_busy, o_done         status
module df_tile_iterator #(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 12
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_order,
  input  logic [CNT_W-1:0]  i_x_lim,
  input  logic [CNT_W-1:0]  i_y_lim,
  input  logic [CNT_W-1:0]  i_k_lim,
  input  logic [CNT_W-1:0]  i_c_lim,
  input  logic [ADDR_W-1:0] i_ps_x_step,
  input  logic [ADDR_W-1:0] i_ps_y_step,
  input  logic [ADDR_W-1:0] i_ps_k_step,
  input  logic [ADDR_W-1:0] i_if_x_step,
  input  logic [ADDR_W-1:0] i_if_y_step,
  input  logic [ADDR_W-1:0] i_if_c_step,
  input  logic [ADDR_W-1:0] i_wt_k_step,
  input  logic [ADDR_W-1:0] i_wt_c_step,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_ps_offs,
  output logic [ADDR_W-1:0] o_if_offs,
  output logic [ADDR_W-1:0] o_wt_offs,
  output logic              o_first_c,
  output logic              o_last_c,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_n;

  // Latched configuration
  logic              order_q;
  logic [CNT_W-1:0]  x_lim_q, y_lim_q, k_lim_q, c_lim_q;
  logic [ADDR_W-1:0] ps_x_step_q, ps_y_step_q, ps_k_step_q;
  logic [ADDR_W-1:0] if_x_step_q, if_y_step_q, if_c_step_q;
  logic [ADDR_W-1:0] wt_k_step_q, wt_c_step_q;

  // Loop counters and per-dimension offset contributions
  logic [CNT_W-1:0]  x_q, y_q, k_q, c_q, x_n, y_n, k_n, c_n;
  logic [ADDR_W-1:0] ps_x_q, ps_y_q, ps_k_q, ps_x_n, ps_y_n, ps_k_n;
  logic [ADDR_W-1:0] if_x_q, if_y_q, if_c_q, if_x_n, if_y_n, if_c_n;
  logic [ADDR_W-1:0] wt_k_q, wt_c_q, wt_k_n, wt_c_n;

  logic x_at, y_at, k_at, c_at;
  logic inc_x, inc_y, inc_k, inc_c;
  logic clr_all, run_n;
  logic [CNT_W-1:0] x_lim_e, y_lim_e, k_lim_e, c_lim_e;

  assign x_at = (x_q == x_lim_q);
  assign y_at = (y_q == y_lim_q);
  assign k_at = (k_q == k_lim_q);
  assign c_at = (c_q == c_lim_q);

  // A level advances when every level inside it sits at its limit.
  assign inc_x = order_q ? 1'b1 : c_at;
  assign inc_y = order_q ? x_at : (c_at & x_at);
  assign inc_c = order_q ? (x_at & y_at) : 1'b1;
  assign inc_k = x_at & y_at & c_at;

  // Flags for the first descriptor must come from the limits being latched.
  assign x_lim_e = (state_q == IDLE) ? i_x_lim : x_lim_q;
  assign y_lim_e = (state_q == IDLE) ? i_y_lim : y_lim_q;
  assign k_lim_e = (state_q == IDLE) ? i_k_lim : k_lim_q;
  assign c_lim_e = (state_q == IDLE) ? i_c_lim : c_lim_q;

  always_comb begin
    state_n = state_q;
    clr_all = 1'b0;
    x_n = x_q;  y_n = y_q;  k_n = k_q;  c_n = c_q;
    ps_x_n = ps_x_q;  ps_y_n = ps_y_q;  ps_k_n = ps_k_q;
    if_x_n = if_x_q;  if_y_n = if_y_q;  if_c_n = if_c_q;
    wt_k_n = wt_k_q;  wt_c_n = wt_c_q;
    if (i_clear) begin
      state_n = IDLE;
      clr_all = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          state_n = RUN;
          clr_all = 1'b1;
        end
        RUN: if (i_ready) begin
          if (o_last) begin
            state_n = DONE;
            clr_all = 1'b1;
          end else begin
            if (inc_x) begin
              if (x_at) {x_n, ps_x_n, if_x_n} = '0;
              else begin
                x_n    = x_q + CNT_W'(1);
                ps_x_n = ps_x_q + ps_x_step_q;
                if_x_n = if_x_q + if_x_step_q;
              end
            end
            if (inc_y) begin
              if (y_at) {y_n, ps_y_n, if_y_n} = '0;
              else begin
                y_n    = y_q + CNT_W'(1);
                ps_y_n = ps_y_q + ps_y_step_q;
                if_y_n = if_y_q + if_y_step_q;
              end
            end
            if (inc_k) begin
              if (k_at) {k_n, ps_k_n, wt_k_n} = '0;
              else begin
                k_n    = k_q + CNT_W'(1);
                ps_k_n = ps_k_q + ps_k_step_q;
                wt_k_n = wt_k_q + wt_k_step_q;
              end
            end
            if (inc_c) begin
              if (c_at) {c_n, if_c_n, wt_c_n} = '0;
              else begin
                c_n    = c_q + CNT_W'(1);
                if_c_n = if_c_q + if_c_step_q;
                wt_c_n = wt_c_q + wt_c_step_q;
              end
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    if (clr_all) begin
      {x_n, y_n, k_n, c_n} = '0;
      {ps_x_n, ps_y_n, ps_k_n} = '0;
      {if_x_n, if_y_n, if_c_n} = '0;
      {wt_k_n, wt_c_n} = '0;
    end
  end

  assign run_n = (state_n == RUN);

  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_start && !i_clear) begin
      order_q     <= i_order;
      x_lim_q     <= i_x_lim;
      y_lim_q     <= i_y_lim;
      k_lim_q     <= i_k_lim;
      c_lim_q     <= i_c_lim;
      ps_x_step_q <= i_ps_x_step;
      ps_y_step_q <= i_ps_y_step;
      ps_k_step_q <= i_ps_k_step;
      if_x_step_q <= i_if_x_step;
      if_y_step_q <= i_if_y_step;
      if_c_step_q <= i_if_c_step;
      wt_k_step_q <= i_wt_k_step;
      wt_c_step_q <= i_wt_c_step;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      {x_q, y_q, k_q, c_q} <= '0;
      {ps_x_q, ps_y_q, ps_k_q} <= '0;
      {if_x_q, if_y_q, if_c_q} <= '0;
      {wt_k_q, wt_c_q} <= '0;
      o_valid   <= 1'b0;
      o_ps_offs <= '0;
      o_if_offs <= '0;
      o_wt_offs <= '0;
      o_first_c <= 1'b0;
      o_last_c  <= 1'b0;
      o_last    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q <= x_n;  y_q <= y_n;  k_q <= k_n;  c_q <= c_n;
      ps_x_q <= ps_x_n;  ps_y_q <= ps_y_n;  ps_k_q <= ps_k_n;
      if_x_q <= if_x_n;  if_y_q <= if_y_n;  if_c_q <= if_c_n;
      wt_k_q <= wt_k_n;  wt_c_q <= wt_c_n;
      o_valid   <= run_n;
      o_ps_offs <= ps_x_n + ps_y_n + ps_k_n;
      o_if_offs <= if_x_n + if_y_n + if_c_n;
      o_wt_offs <= wt_k_n + wt_c_n;
      o_first_c <= run_n & (c_n == '0);
      o_last_c  <= run_n & (c_n == c_lim_e);
      o_last    <= run_n & (c_n == c_lim_e) & (x_n == x_lim_e)
                   & (y_n == y_lim_e) & (k_n == k_lim_e);
      o_busy    <= (state_n != IDLE);
      o_done    <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_df_tile_iterator.sv
module tb_df_tile_iterator;

  localparam int AW = 24;
  localparam int CW = 12;

  typedef struct {
    int xl, yl, kl, cl;
    bit ord;
    logic [23:0] psx, psy, psk, ifx, ify, ifc, wtk, wtc;
  } cfg_t;

  logic i_clk, i_rstn, i_start, i_clear, i_order, i_ready;
  logic [CW-1:0] i_x_lim, i_y_lim, i_k_lim, i_c_lim;
  logic [AW-1:0] i_ps_x_step, i_ps_y_step, i_ps_k_step;
  logic [AW-1:0] i_if_x_step, i_if_y_step, i_if_c_step;
  logic [AW-1:0] i_wt_k_step, i_wt_c_step;
  logic o_valid, o_first_c, o_last_c, o_last, o_busy, o_done;
  logic [AW-1:0] o_ps_offs, o_if_offs, o_wt_offs;

  int n_chk = 0;
  int n_pass = 0;

  logic [23:0] e_ps[$], e_if[$], e_wt[$], seen_ps[$];
  bit e_fc[$], e_lc[$];

  df_tile_iterator #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_clear(i_clear),
    .i_order(i_order),
    .i_x_lim(i_x_lim), .i_y_lim(i_y_lim), .i_k_lim(i_k_lim), .i_c_lim(i_c_lim),
    .i_ps_x_step(i_ps_x_step), .i_ps_y_step(i_ps_y_step), .i_ps_k_step(i_ps_k_step),
    .i_if_x_step(i_if_x_step), .i_if_y_step(i_if_y_step), .i_if_c_step(i_if_c_step),
    .i_wt_k_step(i_wt_k_step), .i_wt_c_step(i_wt_c_step),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_ps_offs(o_ps_offs), .o_if_offs(o_if_offs), .o_wt_offs(o_wt_offs),
    .o_first_c(o_first_c), .o_last_c(o_last_c), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: descriptor = dot product of tile indices and steps, mod 2^24.
  function automatic void push(cfg_t c, int x, int y, int k, int cc);
    longint ps, fi, wt;
    ps = x * longint'(c.psx) + y * longint'(c.psy) + k * longint'(c.psk);
    fi = x * longint'(c.ifx) + y * longint'(c.ify) + cc * longint'(c.ifc);
    wt = k * longint'(c.wtk) + cc * longint'(c.wtc);
    e_ps.push_back(ps[23:0]);
    e_if.push_back(fi[23:0]);
    e_wt.push_back(wt[23:0]);
    e_fc.push_back(cc == 0);
    e_lc.push_back(cc == c.cl);
  endfunction

  function automatic void build_model(cfg_t c);
    e_ps.delete(); e_if.delete(); e_wt.delete(); e_fc.delete(); e_lc.delete();
    for (int k = 0; k <= c.kl; k++) begin
      if (!c.ord) begin
        for (int y = 0; y <= c.yl; y++)
          for (int x = 0; x <= c.xl; x++)
            for (int cc = 0; cc <= c.cl; cc++) push(c, x, y, k, cc);
      end else begin
        for (int cc = 0; cc <= c.cl; cc++)
          for (int y = 0; y <= c.yl; y++)
            for (int x = 0; x <= c.xl; x++) push(c, x, y, k, cc);
      end
    end
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.xl = $urandom_range(0, 3); c.yl = $urandom_range(0, 2);
    c.kl = $urandom_range(0, 2); c.cl = $urandom_range(0, 3);
    c.ord = 1'($urandom_range(0, 1));
    c.psx = 24'($urandom); c.psy = 24'($urandom); c.psk = 24'($urandom);
    c.ifx = 24'($urandom); c.ify = 24'($urandom); c.ifc = 24'($urandom);
    c.wtk = 24'($urandom); c.wtc = 24'($urandom);
    return c;
  endfunction

  function automatic cfg_t base_cfg(bit ord);
    cfg_t c;
    c.xl = 1; c.yl = 0; c.kl = 0; c.cl = 1; c.ord = ord;
    c.psx = 24'd4; c.psy = '0; c.psk = '0;
    c.ifx = 24'd4; c.ify = '0; c.ifc = 24'd100;
    c.wtk = '0; c.wtc = 24'd8;
    return c;
  endfunction

  task automatic apply_cfg(input cfg_t c);
    i_x_lim = 12'(c.xl); i_y_lim = 12'(c.yl); i_k_lim = 12'(c.kl); i_c_lim = 12'(c.cl);
    i_order = c.ord;
    i_ps_x_step = c.psx; i_ps_y_step = c.psy; i_ps_k_step = c.psk;
    i_if_x_step = c.ifx; i_if_y_step = c.ify; i_if_c_step = c.ifc;
    i_wt_k_step = c.wtk; i_wt_c_step = c.wtc;
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_scn(input cfg_t c, input int rmode, input int clr_beat);
    int n, idx, cyc;
    bit stalled, r;
    logic [23:0] hps, hif, hwt;
    build_model(c);
    n = e_ps.size(); idx = 0; cyc = 0; stalled = 0;
    seen_ps.delete();
    @(negedge i_clk);
    apply_cfg(c); i_start = 1'b1; i_ready = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    apply_cfg(rand_cfg());
    while (idx < n && cyc < 4000) begin
      if (stalled) begin
        check("hold_ps", 32'(o_ps_offs), 32'(hps));
        check("hold_if", 32'(o_if_offs), 32'(hif));
        check("hold_wt", 32'(o_wt_offs), 32'(hwt));
      end
      check("valid", 32'(o_valid), 32'd1);
      if (idx == clr_beat) begin
        i_clear = 1'b1; i_start = 1'b1; i_ready = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0; i_start = 1'b0; i_ready = 1'b0;
        check("clr_valid", 32'(o_valid), 32'd0);
        check("clr_busy", 32'(o_busy), 32'd0);
        check("clr_done", 32'(o_done), 32'd0);
        @(negedge i_clk);
        check("clr_done2", 32'(o_done), 32'd0);
        check("clr_valid2", 32'(o_valid), 32'd0);
        return;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      i_ready = r;
      if (r) begin
        check("ps", 32'(o_ps_offs), 32'(e_ps[idx]));
        check("if", 32'(o_if_offs), 32'(e_if[idx]));
        check("wt", 32'(o_wt_offs), 32'(e_wt[idx]));
        check("first_c", 32'(o_first_c), 32'(e_fc[idx]));
        check("last_c", 32'(o_last_c), 32'(e_lc[idx]));
        check("last", 32'(o_last), 32'(idx == n - 1));
        seen_ps.push_back(o_ps_offs);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hps = o_ps_offs; hif = o_if_offs; hwt = o_wt_offs;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_ready = 1'b0;
    if (idx < n) begin
      check("timeout_beats", 32'(idx), 32'(n));
    end else begin
      check("done_pulse", 32'(o_done), 32'd1);
      check("done_valid", 32'(o_valid), 32'd0);
      check("done_busy", 32'(o_busy), 32'd1);
      @(negedge i_clk);
      check("idle_done", 32'(o_done), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_valid", 32'(o_valid), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_ps"}, 32'(o_ps_offs), 32'd0);
    check({tag, "_if"}, 32'(o_if_offs), 32'd0);
    check({tag, "_wt"}, 32'(o_wt_offs), 32'd0);
    check({tag, "_flags"}, 32'({o_first_c, o_last_c, o_last}), 32'd0);
  endtask

  initial begin
    int ref1[4];
    int refw[3];
    cfg_t c;
    i_rstn = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
    apply_cfg(base_cfg(1'b0));
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rstn = 1'b1;

    // Order 0 baseline, plus literal ps sequence
    run_scn(base_cfg(1'b0), 0, -1);
    ref1 = '{0, 0, 4, 4};
    for (int i = 0; i < 4; i++) check("tbl_ps_o0", 32'(seen_ps[i]), 32'(ref1[i]));

    // Order 1
    run_scn(base_cfg(1'b1), 0, -1);
    ref1 = '{0, 4, 0, 4};
    for (int i = 0; i < 4; i++) check("tbl_ps_o1", 32'(seen_ps[i]), 32'(ref1[i]));

    // All limits zero
    c = base_cfg(1'b0); c.xl = 0; c.cl = 0;
    run_scn(c, 0, -1);
    check("single_beats", 32'(seen_ps.size()), 32'd1);

    // Wrap
    c = base_cfg(1'b0); c.xl = 2; c.cl = 0; c.psx = 24'hFFFFFF;
    run_scn(c, 0, -1);
    refw = '{32'h0, 32'hFFFFFF, 32'hFFFFFE};
    for (int i = 0; i < 3; i++) check("tbl_wrap", 32'(seen_ps[i]), 32'(refw[i]));

    // Backpressure
    run_scn(base_cfg(1'b0), 1, -1);
    ref1 = '{0, 0, 4, 4};
    for (int i = 0; i < 4; i++) check("tbl_bp", 32'(seen_ps[i]), 32'(ref1[i]));

    // Clear on beat 2 with start, then fresh start
    run_scn(base_cfg(1'b0), 0, 1);
    run_scn(base_cfg(1'b0), 0, -1);

    // Async reset mid-run
    @(negedge i_clk);
    apply_cfg(base_cfg(1'b0)); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    #2 i_rstn = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge i_clk);
    i_rstn = 1'b1; i_ready = 1'b0;
    @(negedge i_clk);
    check_all_zero("post_rst");

    // Randomized configurations
    for (int t = 0; t < 8; t++) run_scn(rand_cfg(), 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
